// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
package seg7_pkg;

    // Output codes for non-numeric glyphs
    localparam logic [3:0] CODE_L     = 4'hA;
    localparam logic [3:0] CODE_E     = 4'hB;
    localparam logic [3:0] CODE_U     = 4'hC;
    localparam logic [3:0] CODE_BAD   = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-low segment patterns, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

    // Number of active (low) anode enables
    function automatic logic [2:0] count_low(input logic [3:0] an);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

    // Position of the single low anode bit; only meaningful when exactly one is low
    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from active-low segment pattern to display code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       bad_o
);

    // Map each recognised glyph; anything else is flagged as a bad pattern
    always_comb begin
        bad_o = 1'b0;
        case (seg_i)
            SEG_0:     code_o = 4'h0;
            SEG_1:     code_o = 4'h1;
            SEG_2:     code_o = 4'h2;
            SEG_3:     code_o = 4'h3;
            SEG_4:     code_o = 4'h4;
            SEG_5:     code_o = 4'h5;
            SEG_6:     code_o = 4'h6;
            SEG_7:     code_o = 4'h7;
            SEG_8:     code_o = 4'h8;
            SEG_9:     code_o = 4'h9;
            SEG_L:     code_o = CODE_L;
            SEG_E:     code_o = CODE_E;
            SEG_U:     code_o = CODE_U;
            SEG_BLANK: code_o = CODE_BLANK;
            default: begin
                code_o = CODE_BAD;
                bad_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digit codes from a multiplexed seven-segment scan bus.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [3:0]  DIGIT_MASK     = 4'b1011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits_out,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        bad_pattern,
    output logic        stale
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
    localparam logic [7:0] SettleLast = 8'(STABLE_CYCLES - 1);

    state_e         state_q, state_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     cand_an_q, cand_an_d;
    logic [6:0]     cand_seg_q, cand_seg_d;
    logic [7:0]     settle_cnt_q, settle_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [15:0]    digits_q, digits_d;
    logic [3:0]     valid_q, valid_d;
    logic [3:0]     seen_q, seen_d;
    logic           frame_q, frame_d;
    logic           bad_q, bad_d;
    logic           stale_q, stale_d;

    logic [2:0]     n_low;
    logic           is_cand;
    logic           multi_an;
    logic           same;
    logic           capture;
    logic [1:0]     idx;
    logic [3:0]     dec_code;
    logic           dec_bad;
    logic           frame_done;
    logic [TmoW-1:0] tmo_inc;

    seg7_pattern_decode u_decode (
        .seg_i  (seg_q),
        .code_o (dec_code),
        .bad_o  (dec_bad)
    );

    assign n_low      = count_low(an_q);
    assign is_cand    = (n_low == 3'd1);
    assign multi_an   = (n_low > 3'd1);
    assign same       = (an_q == cand_an_q) && (seg_q == cand_seg_q);
    assign idx        = an_index(an_q);
    assign frame_done = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
    assign tmo_inc    = tmo_q + 1'b1;

    // Dwell FSM: qualify a candidate for STABLE_CYCLES identical samples, then hold
    always_comb begin
        state_d      = state_q;
        cand_an_d    = cand_an_q;
        cand_seg_d   = cand_seg_q;
        settle_cnt_d = settle_cnt_q;
        capture      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_cand) begin
                    state_d      = StSettle;
                    settle_cnt_d = 8'd1;
                    cand_an_d    = an_q;
                    cand_seg_d   = seg_q;
                end
            end
            StSettle: begin
                if (!is_cand) begin
                    state_d      = StIdle;
                    settle_cnt_d = 8'd0;
                end else if (same) begin
                    if (settle_cnt_q == SettleLast) begin
                        state_d      = StHold;
                        settle_cnt_d = 8'd0;
                        capture      = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end else begin
                    // A different digit or pattern restarts qualification
                    settle_cnt_d = 8'd1;
                    cand_an_d    = an_q;
                    cand_seg_d   = seg_q;
                end
            end
            StHold: begin
                if (!same) begin
                    state_d      = StIdle;
                    settle_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d      = StIdle;
                settle_cnt_d = 8'd0;
            end
        endcase
    end

    // Capture, frame tracking, error flag and staleness timeout
    always_comb begin
        an_d     = an_in;
        seg_d    = seg_in;
        digits_d = digits_q;
        valid_d  = valid_q;
        tmo_d    = tmo_q;
        stale_d  = stale_q;
        frame_d  = frame_done;
        // A completed frame clears the mask; a coincident capture re-adds only its own bit
        seen_d   = frame_done ? 4'b0000 : seen_q;
        bad_d    = bad_q | multi_an;

        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (idx == 2'(i)) begin
                    digits_d[i*4 +: 4] = dec_code;
                end
            end
            valid_d[idx] = 1'b1;
            seen_d[idx]  = 1'b1;
            bad_d        = bad_d | dec_bad;
            tmo_d        = '0;
            stale_d      = 1'b0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TmoMax) begin
                stale_d = 1'b1;
                valid_d = 4'b0000;
                seen_d  = 4'b0000;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            cand_an_q    <= 4'b1111;
            cand_seg_q   <= 7'b1111111;
            settle_cnt_q <= 8'd0;
            tmo_q        <= '0;
            digits_q     <= 16'hFFFF;
            valid_q      <= 4'b0000;
            seen_q       <= 4'b0000;
            frame_q      <= 1'b0;
            bad_q        <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            cand_an_q    <= cand_an_d;
            cand_seg_q   <= cand_seg_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_q        <= tmo_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            frame_q      <= frame_d;
            bad_q        <= bad_d;
            stale_q      <= stale_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign bad_pattern = bad_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever the outputs change or frame_valid pulses.
module tb_seg7_scan_decoder;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg_in = 7'b1111111;
    logic [3:0]  an_in = 4'b1111;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        bad_pattern;
    logic        stale;

    seg7_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .DIGIT_MASK     (4'b1011)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [3:0]  v;
        logic        fv;
        logic        bad;
        logic        stale;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Bench-side model of the visible output state
    logic [15:0] m_d;
    logic [3:0]  m_v;
    logic [3:0]  m_seen;
    logic        m_bad;
    logic        m_stale;

    logic [22:0] snap;
    logic [22:0] prev;
    assign snap = {digits_out, digit_valid, bad_pattern, stale};

    // Monitor: every output change or frame pulse is one event to be matched
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev = snap;
        end else begin
            if (frame_valid || snap != prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cyc %0d got d=%h v=%b fv=%b bad=%b stale=%b, required no event",
                             cyc, digits_out, digit_valid, frame_valid, bad_pattern, stale);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.d != digits_out || e.v != digit_valid ||
                        e.fv != frame_valid || e.bad != bad_pattern || e.stale != stale) begin
                        n_fail++;
                        $display("FAIL event: got cyc %0d d=%h v=%b fv=%b bad=%b stale=%b, required cyc %0d d=%h v=%b fv=%b bad=%b stale=%b",
                                 cyc, digits_out, digit_valid, frame_valid, bad_pattern, stale,
                                 e.cyc, e.d, e.v, e.fv, e.bad, e.stale);
                    end
                end
            end
            prev = snap;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int c, input logic fv);
        exp_t e;
        e.cyc   = c;
        e.d     = m_d;
        e.v     = m_v;
        e.fv    = fv;
        e.bad   = m_bad;
        e.stale = m_stale;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_digits"}, 32'(digits_out), 32'h0000FFFF);
        check({name, "_valid"}, 32'(digit_valid), 32'h0);
        check({name, "_frame"}, 32'(frame_valid), 32'h0);
        check({name, "_bad"}, 32'(bad_pattern), 32'h0);
        check({name, "_stale"}, 32'(stale), 32'h0);
    endtask

    task automatic model_reset();
        m_d     = 16'hFFFF;
        m_v     = 4'b0000;
        m_seen  = 4'b0000;
        m_bad   = 1'b0;
        m_stale = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst_n  = 1'b0;
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        #1;
        check_reset_vals(name);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Present one anode dwell for n cycles followed by a two-cycle blank gap
    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n,
                         input int idx, input logic [3:0] code, input logic capt);
        int k;
        k      = cyc;
        an_in  = an;
        seg_in = seg;
        if (capt) begin
            m_d[idx*4 +: 4] = code;
            m_v[idx]        = 1'b1;
            m_seen[idx]     = 1'b1;
            if (code == 4'hD) m_bad = 1'b1;
            m_stale = 1'b0;
            push(k + STABLE + 1, 1'b0);
            if ((m_seen & 4'b1011) == 4'b1011) begin
                push(k + STABLE + 2, 1'b1);
                m_seen = 4'b0000;
            end
        end
        repeat (n) tick();
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        repeat (2) tick();
    endtask

    initial begin
        int k;
        model_reset();
        #2;
        do_reset("rst0");

        // Digit 0 shows "2" for exactly STABLE cycles: captured 5 cycles later
        dwell(4'b1110, 7'b0100100, 4, 0, 4'h2, 1'b1);
        repeat (2) tick();
        check("cap2_digits", 32'(digits_out), 32'h0000FFF2);
        // Digit 1 shows "3" for one cycle too few: nothing captured
        dwell(4'b1101, 7'b0110000, 3, 1, 4'h3, 1'b0);
        repeat (4) tick();
        check("short_valid", 32'(digit_valid), 32'h1);
        check("short_digits", 32'(digits_out), 32'h0000FFF2);
        // "9" for two cycles then "8": qualification restarts on the new pattern
        an_in  = 4'b1101;
        seg_in = 7'b0010000;
        repeat (2) tick();
        dwell(4'b1101, 7'b0000000, 5, 1, 4'h8, 1'b1);
        check("restart_digits", 32'(digits_out), 32'h0000FF82);

        // Frame: U on digit 0, 5 on digit 1, 4 on digit 3
        do_reset("rst1");
        dwell(4'b1110, 7'b1000001, 6, 0, 4'hC, 1'b1);
        dwell(4'b1101, 7'b0010010, 6, 1, 4'h5, 1'b1);
        dwell(4'b0111, 7'b0011001, 6, 3, 4'h4, 1'b1);
        repeat (3) tick();
        check("frame_digits", 32'(digits_out), 32'h00004F5C);
        check("frame_pulse_gone", 32'(frame_valid), 32'h0);

        // Two anodes low: ignored, sticky bad flag
        do_reset("rst2");
        k      = cyc;
        an_in  = 4'b1100;
        seg_in = 7'b0100100;
        m_bad  = 1'b1;
        push(k + 2, 1'b0);
        repeat (10) tick();
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        repeat (8) tick();
        check("multi_bad_sticky", 32'(bad_pattern), 32'h1);
        check("multi_no_capture", 32'(digit_valid), 32'h0);
        check("multi_digits", 32'(digits_out), 32'h0000FFFF);

        // Unknown pattern on digit 2, then L on digit 0 and blank on digit 3
        do_reset("rst3");
        dwell(4'b1011, 7'b0101010, 6, 2, 4'hD, 1'b1);
        dwell(4'b1110, 7'b1000111, 6, 0, 4'hA, 1'b1);
        dwell(4'b0111, 7'b1111111, 6, 3, 4'hF, 1'b1);
        check("badseg_digits", 32'(digits_out), 32'h0000FDFA);
        check("badseg_flag", 32'(bad_pattern), 32'h1);

        // Timeout: stale exactly TIMEOUT cycles after the last capture
        do_reset("rst4");
        k = cyc;
        dwell(4'b1110, 7'b0100100, 5, 0, 4'h2, 1'b1);
        m_v     = 4'b0000;
        m_seen  = 4'b0000;
        m_stale = 1'b1;
        push(k + STABLE + 1 + TIMEOUT, 1'b0);
        repeat (TIMEOUT) tick();
        check("stale_flag", 32'(stale), 32'h1);
        check("stale_digits_kept", 32'(digits_out), 32'h0000FFF2);
        dwell(4'b1101, 7'b1111000, 6, 1, 4'h7, 1'b1);
        check("unstale_flag", 32'(stale), 32'h0);
        check("unstale_valid", 32'(digit_valid), 32'h2);

        // Reset in the middle of a settling dwell
        do_reset("rst5");
        dwell(4'b1110, 7'b1111001, 5, 0, 4'h1, 1'b1);
        an_in  = 4'b1101;
        seg_in = 7'b0100100;
        repeat (2) tick();
        #2;
        rst_n  = 1'b0;
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        #1;
        check_reset_vals("midsettle");
        tick();
        rst_n = 1'b1;
        model_reset();
        repeat (8) tick();
        check("midsettle_no_cap_digits", 32'(digits_out), 32'h0000FFFF);
        check("midsettle_no_cap_valid", 32'(digit_valid), 32'h0);

        repeat (3) tick();
        check("events_outstanding", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
